// File: rtl/mmr_noc_arbiter_pkg.sv
// Shared definitions for the MMR NoC arbiter slice.
// Contents: FSM state enum, requester IDs, default bank geometry and doorbell offset.
package mmr_pkg;

  localparam int unsigned DefAddrW       = 3;
  localparam int unsigned DefDataW       = 32;
  localparam int unsigned DefDoorbellIdx = 7;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_CORE = 1'b0;
  localparam req_id_t REQ_NOC  = 1'b1;

endpackage

// File: rtl/mmr_noc_arbiter_if.sv
// Request/response bundle for one MMR requester (core MEM stage or NoC agent).
// master: the requester drives req/we/addr/wdata and receives ack/rdata.
// slave : the arbiter side.
interface mmr_noc_arbiter_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );
endinterface

// File: rtl/mmr_noc_arbiter_rr_arb.sv
// mmr_rr_arb: 2-way round-robin picker.
// Ports:
//   reqs_i       - request vector, indexed by requester ID (REQ_CORE / REQ_NOC)
//   last_grant_i - ID granted most recently
//   winner_o     - ID to grant; only meaningful when |reqs_i
module mmr_rr_arb
  import mmr_pkg::*;
(
  input  logic [1:0] reqs_i,
  input  req_id_t    last_grant_i,
  output req_id_t    winner_o
);

  always_comb begin
    winner_o = REQ_CORE;
    if (reqs_i[REQ_CORE] && reqs_i[REQ_NOC]) begin
      // Tie: the requester not served last goes next.
      winner_o = ~last_grant_i;
    end else if (reqs_i[REQ_NOC]) begin
      winner_o = REQ_NOC;
    end
  end

endmodule

// File: rtl/mmr_noc_arbiter.sv
// mmr_noc_arbiter: owns the MMR word bank behind LOADNOC/STORENOC and serialises
// accesses from the pipeline MEM stage and the NoC agent with round-robin fairness.
// Each access takes IDLE -> ACCESS -> DONE; ack is a one-cycle pulse in DONE.
// Ports:
//   clk, reset  - single clock, asynchronous active-high reset
//   core_if     - core requester (slave modport of mmr_noc_arbiter_if)
//   noc_if      - NoC requester (slave modport of mmr_noc_arbiter_if)
//   core_stall  - core_req & ~core_ack, combinational pipeline stall
//   noc_irq     - doorbell pending
// Build option: MMR_DOORBELL_EN enables the doorbell at DOORBELL_IDX; otherwise
// noc_irq is tied low and DOORBELL_IDX is an ordinary register.
module mmr_noc_arbiter
  import mmr_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned DOORBELL_IDX = DefDoorbellIdx
) (
  input  logic                clk,
  input  logic                reset,
  mmr_noc_arbiter_if.slave    core_if,
  mmr_noc_arbiter_if.slave    noc_if,
  output logic                core_stall,
  output logic                noc_irq
);

  localparam int unsigned Depth = 1 << ADDR_W;

  if (DOORBELL_IDX >= Depth) begin : g_bad_doorbell
    $error("DOORBELL_IDX outside the MMR bank");
  end

  state_e            state_q, state_d;
  req_id_t           grant_q, grant_d;
  req_id_t           last_q, last_d;
  logic              core_ack_q, core_ack_d;
  logic              noc_ack_q, noc_ack_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] noc_rdata_q, noc_rdata_d;

  // Request fields captured at grant so a requester may drop req afterwards.
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [DATA_W-1:0] bank_q [Depth];
  logic              bank_we;

  logic [1:0]        reqs;
  req_id_t           winner;

`ifdef MMR_DOORBELL_EN
  logic              irq_q, irq_d;
`endif

  assign reqs = {noc_if.req, core_if.req};

  mmr_rr_arb u_rr_arb (
    .reqs_i       (reqs),
    .last_grant_i (last_q),
    .winner_o     (winner)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    core_ack_d   = 1'b0;
    noc_ack_d    = 1'b0;
    core_rdata_d = core_rdata_q;
    noc_rdata_d  = noc_rdata_q;
`ifdef MMR_DOORBELL_EN
    irq_d        = irq_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|reqs) begin
          grant_d = winner;
          last_d  = winner;
          if (winner == REQ_CORE) begin
            we_d    = core_if.we;
            addr_d  = core_if.addr;
            wdata_d = core_if.wdata;
          end else begin
            we_d    = noc_if.we;
            addr_d  = noc_if.addr;
            wdata_d = noc_if.wdata;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (grant_q == REQ_CORE) begin
          core_ack_d = 1'b1;
          if (!we_q) core_rdata_d = bank_q[addr_q];
        end else begin
          noc_ack_d = 1'b1;
          if (!we_q) noc_rdata_d = bank_q[addr_q];
        end
`ifdef MMR_DOORBELL_EN
        if (addr_q == ADDR_W'(DOORBELL_IDX)) begin
          if (we_q && grant_q == REQ_CORE) begin
            irq_d = 1'b1;
          end else if (!we_q && grant_q == REQ_NOC) begin
            irq_d = 1'b0;
          end
        end
`endif
        state_d = DONE;
      end
      DONE: begin
        // No grant here: a requester that drops req on ack is never re-served.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= REQ_CORE;
      last_q       <= REQ_NOC;
      core_ack_q   <= 1'b0;
      noc_ack_q    <= 1'b0;
      core_rdata_q <= '0;
      noc_rdata_q  <= '0;
`ifdef MMR_DOORBELL_EN
      irq_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      core_ack_q   <= core_ack_d;
      noc_ack_q    <= noc_ack_d;
      core_rdata_q <= core_rdata_d;
      noc_rdata_q  <= noc_rdata_d;
`ifdef MMR_DOORBELL_EN
      irq_q        <= irq_d;
`endif
    end
  end

  // Captured request fields carry no reset; they are only consumed after a grant.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Gating with reset drops a write whose ACCESS edge lands while reset is asserted.
  assign bank_we = (state_q == ACCESS) && we_q && !reset;

  always_ff @(posedge clk) begin
    if (bank_we) bank_q[addr_q] <= wdata_q;
  end

  assign core_if.ack   = core_ack_q;
  assign core_if.rdata = core_rdata_q;
  assign noc_if.ack    = noc_ack_q;
  assign noc_if.rdata  = noc_rdata_q;
  assign core_stall    = core_if.req & ~core_ack_q;

`ifdef MMR_DOORBELL_EN
  assign noc_irq = irq_q;
`else
  assign noc_irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmr_noc_arbiter.sv
// Self-checking bench for mmr_noc_arbiter: a transaction-level model (bank array,
// next-free-edge scheduler, last-served ID) predicts every output each cycle, and
// directed scenarios add hand-computed literal checks.
module tb_mmr_noc_arbiter;

  logic clk;
  logic reset;
  logic core_stall;
  logic noc_irq;

  mmr_noc_arbiter_if core_if ();
  mmr_noc_arbiter_if noc_if ();

  mmr_noc_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .core_if    (core_if),
    .noc_if     (noc_if),
    .core_stall (core_stall),
    .noc_irq    (noc_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_core_acks = 0;
  int n_noc_acks = 0;
  int n_stall = 0;
  bit order_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        e_cack = 1'b0;
  logic        e_nack = 1'b0;
  logic [31:0] e_crd = '0;
  logic [31:0] e_nrd = '0;
  logic        e_irq = 1'b0;
  logic [31:0] m_mem [8];

  initial begin : model
    int   edge_n;
    int   free_e;
    bit   pend;
    bit   last;
    bit   who;
    logic mwe;
    logic [2:0]  maddr;
    logic [31:0] mwd;
    edge_n = 0;
    free_e = 0;
    pend   = 0;
    last   = 1;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        pend   = 0;
        free_e = 0;
        last   = 1;
        e_cack = 0;
        e_nack = 0;
        e_crd  = '0;
        e_nrd  = '0;
        e_irq  = 0;
      end else begin
        edge_n++;
        e_cack = 0;
        e_nack = 0;
        if (pend) begin
          // Access happens one edge after grant; next grant two edges later.
          pend   = 0;
          free_e = edge_n + 2;
          if (mwe) begin
            m_mem[maddr] = mwd;
`ifdef MMR_DOORBELL_EN
            if (maddr == 3'd7 && who == 0) e_irq = 1;
`endif
          end else begin
            if (who == 0) e_crd = m_mem[maddr];
            else e_nrd = m_mem[maddr];
`ifdef MMR_DOORBELL_EN
            if (maddr == 3'd7 && who == 1) e_irq = 0;
`endif
          end
          if (who == 0) e_cack = 1;
          else e_nack = 1;
        end else if (edge_n >= free_e && (core_if.req || noc_if.req)) begin
          if (core_if.req && noc_if.req) who = ~last;
          else who = noc_if.req;
          last  = who;
          pend  = 1;
          mwe   = who ? noc_if.we : core_if.we;
          maddr = who ? noc_if.addr : core_if.addr;
          mwd   = who ? noc_if.wdata : core_if.wdata;
        end
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("core_ack", {31'b0, core_if.ack}, {31'b0, e_cack});
    chk("noc_ack", {31'b0, noc_if.ack}, {31'b0, e_nack});
    chk("core_rdata", core_if.rdata, e_crd);
    chk("noc_rdata", noc_if.rdata, e_nrd);
    chk("noc_irq", {31'b0, noc_irq}, {31'b0, e_irq});
    chk("core_stall", {31'b0, core_stall}, {31'b0, core_if.req & ~e_cack});
    if (core_if.ack === 1'b1) begin n_core_acks++; order_q.push_back(1'b0); end
    if (noc_if.ack === 1'b1) begin n_noc_acks++; order_q.push_back(1'b1); end
    if (core_stall === 1'b1) n_stall++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit p, input logic r, input logic we, input logic [2:0] a,
                       input logic [31:0] wd);
    if (p) begin
      noc_if.req = r; noc_if.we = we; noc_if.addr = a; noc_if.wdata = wd;
    end else begin
      core_if.req = r; core_if.we = we; core_if.addr = a; core_if.wdata = wd;
    end
  endtask

  function automatic logic port_ack(input bit p);
    return p ? noc_if.ack : core_if.ack;
  endfunction

  task automatic txn(input bit p, input logic we, input logic [2:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output int req_c, output int ack_c);
    int budget;
    @(posedge clk);
    #1;
    drive(p, 1'b1, we, a, wd);
    req_c  = cyc;
    budget = 0;
    while (port_ack(p) !== 1'b1 && budget < 20) begin
      @(posedge clk);
      #1;
      budget++;
    end
    ack_c = cyc;
    if (port_ack(p) !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL txn_timeout: port %0d got no ack, required ack within 20 cycles", p);
      rd = 'x;
    end else begin
      rd = p ? noc_if.rdata : core_if.rdata;
    end
    drive(p, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main
    logic [31:0] rd, rd2;
    int rq, ak, rq2, ak2, acks_before;
    bit exp_order [6];
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    chk("rst_core_ack", {31'b0, core_if.ack}, 32'd0);
    chk("rst_noc_ack", {31'b0, noc_if.ack}, 32'd0);
    chk("rst_core_rdata", core_if.rdata, 32'd0);
    chk("rst_noc_rdata", noc_if.rdata, 32'd0);
    chk("rst_irq", {31'b0, noc_irq}, 32'd0);

    // Preload: bank[i] = i except bank[2] = 0x2A.
    for (int i = 0; i < 8; i++) begin
      txn(1'b0, 1'b1, 3'(i), (i == 2) ? 32'h2A : 32'(i), rd, rq, ak);
    end

    // Single core read with latency and stall length.
    n_stall = 0;
    txn(1'b0, 1'b0, 3'd2, 32'd0, rd, rq, ak);
    chk("read2_data", rd, 32'h2A);
    chk("read2_latency", 32'(ak - rq), 32'd2);
    @(negedge clk);
    chk("read2_stall_cycles", 32'(n_stall), 32'd2);

    // Tie after reset: core first, noc three cycles later.
    do_reset();
    fork
      txn(1'b0, 1'b1, 3'd5, 32'h11, rd, rq, ak);
      txn(1'b1, 1'b1, 3'd5, 32'h22, rd2, rq2, ak2);
    join
    chk("tie_ack_spacing", 32'(ak2 - ak), 32'd3);
    txn(1'b0, 1'b0, 3'd5, 32'd0, rd, rq, ak);
    chk("tie_final_read", rd, 32'h22);

    // Fairness over six back-to-back transactions.
    do_reset();
    @(negedge clk);
    order_q.delete();
    fork
      for (int i = 0; i < 3; i++) txn(1'b0, 1'b0, 3'd1, 32'd0, rd, rq, ak);
      for (int j = 0; j < 3; j++) txn(1'b1, 1'b0, 3'd4, 32'd0, rd2, rq2, ak2);
    join
    @(negedge clk);
    chk("fair_count", 32'(order_q.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < order_q.size()) chk($sformatf("fair_grant%0d", k), {31'b0, order_q[k]},
                                  {31'b0, exp_order[k]});
    end

    // Early drop: one-cycle noc pulse while core holds its grant.
    acks_before = n_noc_acks;
    fork
      txn(1'b0, 1'b0, 3'd3, 32'd0, rd, rq, ak);
      begin
        @(posedge clk);
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 1'b0, 3'd4, 32'd0);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
      end
    join
    repeat (6) @(posedge clk);
    chk("drop_core_data", rd, 32'd3);
    chk("drop_noc_acks", 32'(n_noc_acks - acks_before), 32'd0);

    // Reset during ACCESS of a core write to addr 1.
    acks_before = n_core_acks;
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 1'b1, 3'd1, 32'h55);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_core_ack", {31'b0, core_if.ack}, 32'd0);
    chk("midrst_core_rdata", core_if.rdata, 32'd0);
    chk("midrst_noc_rdata", noc_if.rdata, 32'd0);
    #2 reset = 1'b0;
    repeat (4) @(posedge clk);
    chk("midrst_no_ack", 32'(n_core_acks - acks_before), 32'd0);
    txn(1'b0, 1'b0, 3'd1, 32'd0, rd, rq, ak);
    chk("midrst_write_lost", rd, 32'h01);

    // Doorbell.
    txn(1'b0, 1'b1, 3'd7, 32'h9, rd, rq, ak);
`ifdef MMR_DOORBELL_EN
    chk("db_irq_set", {31'b0, noc_irq}, 32'd1);
`else
    chk("db_irq_set", {31'b0, noc_irq}, 32'd0);
`endif
    txn(1'b1, 1'b0, 3'd7, 32'd0, rd, rq, ak);
    chk("db_noc_read", rd, 32'h9);
    chk("db_irq_clear", {31'b0, noc_irq}, 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
